cm42_sel_monitor: RTL

Downstream consumer of the CM42 4-to-10 decoder. Samples the ten active-low select lines (e_pad..n_pad), checks that at most one line is low, re-encodes the active line to a 4-bit index, and queues one event per change through a small FIFO with a valid/ready output handshake. Saturating counters track malformed patterns and FIFO overflow drops for the verification and debug harness.

---
 rtl/cm42_sel_monitor.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/cm42_sel_monitor.sv
// cm42_sel_monitor
//   Watches the ten active-low select lines of a CM42 4-to-10 decoder, checks
//   that at most one line is low, re-encodes the active line to a 4-bit index
//   and queues one event per change through a small FIFO with a valid/ready
//   output handshake. Saturating counters record malformed patterns and
//   events lost because the FIFO was full.
//
// Ports
//   clk_pad        in   clock, rising edge
//   rst_pad        in   synchronous active-high reset
//   sel_n_pad      in   [9:0] decoder outputs, active low (bit 0 = e_pad)
//   out_valid_pad  out  event available at FIFO head
//   out_ready_pad  in   consumer accepts the head event
//   out_idx_pad    out  [3:0] head index 0..9, 4'hF for an error event
//   out_err_pad    out  head event is malformed
//   err_cnt_pad    out  [CNT_W-1:0] error events detected, saturating
//   drop_cnt_pad   out  [CNT_W-1:0] events lost to a full FIFO, saturating
module cm42_sel_monitor #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk_pad,
  input  logic             rst_pad,
  input  logic [9:0]       sel_n_pad,
  output logic             out_valid_pad,
  input  logic             out_ready_pad,
  output logic [3:0]       out_idx_pad,
  output logic             out_err_pad,
  output logic [CNT_W-1:0] err_cnt_pad,
  output logic [CNT_W-1:0] drop_cnt_pad
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int OCC_W = PTR_W + 1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                               input logic             en);
    if (en && (v != {CNT_W{1'b1}})) begin
      return v + CNT_W'(1);
    end
    return v;
  endfunction

  logic [9:0]       s1_q, s1_d;
  logic [9:0]       prev_q, prev_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

  // FIFO storage: {err, idx}; data only, never reset.
  logic [4:0]       mem_q [DEPTH];

  logic [3:0]       zero_cnt;
  logic [3:0]       hit_idx;
  logic             ev_valid;
  logic             ev_err;
  logic [4:0]       ev_data;
  logic             fifo_full;
  logic             fifo_nempty;
  logic             pop;
  logic             push;
  logic             drop;
  logic [4:0]       head;

  // Stage S1 classification: count low lines; with exactly one low line the
  // last index recorded in the loop is that line.
  always_comb begin
    zero_cnt = '0;
    hit_idx  = '0;
    for (int i = 0; i < 10; i++) begin
      if (!s1_q[i]) begin
        zero_cnt = zero_cnt + 4'd1;
        hit_idx  = 4'(i);
      end
    end
    ev_err   = (zero_cnt >= 4'd2);
    ev_valid = (s1_q != prev_q) && (zero_cnt != 4'd0);
    ev_data  = ev_err ? {1'b1, 4'hF} : {1'b0, hit_idx};
  end

  // Push/pop decision stage. A pop frees a slot in the same edge, so a full
  // FIFO still accepts an event when the consumer is draining it.
  always_comb begin
    fifo_full   = (occ_q == OCC_W'(DEPTH));
    fifo_nempty = (occ_q != '0);
    pop         = fifo_nempty && out_ready_pad;
    push        = ev_valid && (!fifo_full || pop);
    drop        = ev_valid && fifo_full && !pop;

    s1_d       = sel_n_pad;
    prev_d     = s1_q;
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    occ_d      = occ_q;
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
    err_cnt_d  = sat_inc(err_cnt_q, ev_valid && ev_err);
    drop_cnt_d = sat_inc(drop_cnt_q, drop);
  end

  always_ff @(posedge clk_pad) begin
    if (rst_pad) begin
      s1_q       <= 10'h3FF;
      prev_q     <= 10'h3FF;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      err_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      s1_q       <= s1_d;
      prev_q     <= prev_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      err_cnt_q  <= err_cnt_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  always_ff @(posedge clk_pad) begin
    if (push && !rst_pad) begin
      mem_q[wr_ptr_q] <= ev_data;
    end
  end

  // Output stage: head is shown only while valid, otherwise held at zero.
  always_comb begin
    head          = mem_q[rd_ptr_q];
    out_valid_pad = fifo_nempty;
    out_idx_pad   = fifo_nempty ? head[3:0] : 4'h0;
    out_err_pad   = fifo_nempty ? head[4]   : 1'b0;
    err_cnt_pad   = err_cnt_q;
    drop_cnt_pad  = drop_cnt_q;
  end

endmodule
